// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// offsets, STATUS bit positions and the serialiser state encoding.
package mmio_pkg;

   // Register offsets inside the 8-byte window (selected by data_addr[2])
   localparam logic [2:0] REG_TXDATA_OFF = 3'd0;
   localparam logic [2:0] REG_STATUS_OFF = 3'd4;

   // STATUS bit positions
   localparam int STAT_FULL      = 0;
   localparam int STAT_EMPTY     = 1;
   localparam int STAT_BUSY      = 2;
   localparam int STAT_OVF       = 3;
   localparam int STAT_IRQ_EN    = 4;
   localparam int STAT_COUNT_LSB = 8;

   // Serialiser states; one frame walks START -> DATA -> STOP
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } uart_state_e;

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Single-clock FIFO with a fall-through head: dout always shows the oldest
// entry so the consumer can grab it on the same edge it pops. Pointers carry
// one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign count   = wr_ptr_q - rd_ptr_q;
   assign dout    = mem_q[rd_ptr_q[AW-1:0]];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Pointer advance: writes refused when full, reads refused when empty
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   // Pointer registers; reset discards any stored entries
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array, no reset so it maps onto plain RAM
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter hanging off the core's data port.
// TXDATA (+0) pushes a byte into the TX FIFO, STATUS (+4) reports
// full/empty/busy/overflow/count and clears overflow with a W1C of bit 3.
// Optional feature: define MMIO_UART_IRQ_EN to add the irq output and the
// R/W irq-enable bit in STATUS[4].
module mmio_uart_tx
   import mmio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
   parameter int          CLK_DIV    = 868,
   parameter int          FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] data_addr,
   input  logic [31:0] write_data,
   input  logic        mem_write,
   output logic        sel,
   output logic [31:0] rd_data,
   output logic        tx
`ifdef MMIO_UART_IRQ_EN
   ,
   output logic        irq
`endif
);

   localparam int             CW          = $clog2(FIFO_DEPTH) + 1;
   localparam int             BW          = $clog2(CLK_DIV);
   localparam logic [BW-1:0]  BAUD_RELOAD = BW'(CLK_DIV - 1);

   // Bus decode
   logic        is_status;
   logic        push_req;
   logic        status_wr;

   // FIFO interface
   logic        fifo_pop;
   logic [7:0]  fifo_dout;
   logic        fifo_full;
   logic        fifo_empty;
   logic [CW-1:0] fifo_count;

   // Serialiser state
   uart_state_e   state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          baud_done;

   // Sticky overflow
   logic        overflow_q, overflow_d;
   logic        ovf_set;

   logic [31:0] status;

   // Address bits below the word offset and upper store data never matter
   logic        unused_bits;
   assign unused_bits = ^{data_addr[1:0], write_data[31:8]};

   assign sel       = (data_addr[31:3] == BASE_ADDR[31:3]);
   assign is_status = (data_addr[2] == REG_STATUS_OFF[2]);
   assign push_req  = sel & mem_write & ~is_status;
   assign status_wr = sel & mem_write & is_status;
   assign ovf_set   = push_req & fifo_full;
   assign baud_done = (baud_q == '0);
   assign tx        = tx_q;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_req),
      .pop   (fifo_pop),
      .din   (write_data[7:0]),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Overflow: a dropped push sets it and beats a simultaneous W1C clear
   always_comb begin
      overflow_d = overflow_q;
      if (status_wr && write_data[STAT_OVF]) overflow_d = 1'b0;
      if (ovf_set)                           overflow_d = 1'b1;
   end

   // Frame sequencer: picks the next byte, times each bit, drives tx
   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      tx_d     = tx_q;
      fifo_pop = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (!fifo_empty) begin
               state_d  = S_START;
               fifo_pop = 1'b1;
               shift_d  = fifo_dout;
               baud_d   = BAUD_RELOAD;
               tx_d     = 1'b0;
            end
         end
         S_START: begin
            if (baud_done) begin
               state_d = S_DATA;
               bit_d   = 3'd0;
               baud_d  = BAUD_RELOAD;
               tx_d    = shift_q[0];
            end else begin
               baud_d = baud_q - BW'(1);
            end
         end
         S_DATA: begin
            if (baud_done) begin
               baud_d = BAUD_RELOAD;
               if (bit_q == 3'd7) begin
                  state_d = S_STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
                  tx_d    = shift_q[1];
               end
            end else begin
               baud_d = baud_q - BW'(1);
            end
         end
         S_STOP: begin
            if (baud_done) begin
               baud_d = BAUD_RELOAD;
               if (!fifo_empty) begin
                  // Chain straight into the next start bit, no idle gap
                  state_d  = S_START;
                  fifo_pop = 1'b1;
                  shift_d  = fifo_dout;
                  tx_d     = 1'b0;
               end else begin
                  state_d = S_IDLE;
                  tx_d    = 1'b1;
               end
            end else begin
               baud_d = baud_q - BW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   // Sequencer, shifter and overflow registers; reset forces tx high at once
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         baud_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         overflow_q <= overflow_d;
      end
   end

`ifdef MMIO_UART_IRQ_EN
   logic irq_en_q, irq_en_d;
   logic irq_q, irq_d;

   assign irq = irq_q;

   // TX-complete interrupt, gated by the software enable
   always_comb begin
      irq_en_d = status_wr ? write_data[STAT_IRQ_EN] : irq_en_q;
      irq_d    = irq_en_q & fifo_empty & (state_q == S_IDLE);
   end

   // Interrupt enable and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         irq_en_q <= irq_en_d;
         irq_q    <= irq_d;
      end
   end
`endif

   // STATUS word assembly and read mux; TXDATA and out-of-window read 0
   always_comb begin
      status                             = '0;
      status[STAT_FULL]                  = fifo_full;
      status[STAT_EMPTY]                 = fifo_empty;
      status[STAT_BUSY]                  = (state_q != S_IDLE);
      status[STAT_OVF]                   = overflow_q;
`ifdef MMIO_UART_IRQ_EN
      status[STAT_IRQ_EN]                = irq_en_q;
`endif
      status[STAT_COUNT_LSB +: 8]        = 8'(fifo_count);
      rd_data = (sel && is_status) ? status : 32'h0;
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLK_DIV = 4 and FIFO_DEPTH = 16.
// tx is logged once per cycle (on the falling edge) into a history array so
// whole frames can be compared against hand-built bit patterns afterwards.
module tb_mmio_uart_tx;

   localparam int CLK_DIV = 4;
   localparam int HIST    = 4096;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] data_addr = 32'h0;
   logic [31:0] write_data = 32'h0;
   logic        mem_write = 1'b0;
   logic        sel;
   logic [31:0] rd_data;
   logic        tx;
`ifdef MMIO_UART_IRQ_EN
   logic        irq;
`endif

   mmio_uart_tx #(
      .BASE_ADDR  (32'h0000_1000),
      .CLK_DIV    (CLK_DIV),
      .FIFO_DEPTH (16)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .data_addr  (data_addr),
      .write_data (write_data),
      .mem_write  (mem_write),
      .sel        (sel),
      .rd_data    (rd_data),
      .tx         (tx)
`ifdef MMIO_UART_IRQ_EN
      ,
      .irq        (irq)
`endif
   );

   always #5 clk = ~clk;

   int   cyc = 0;
   logic hist [0:HIST-1];
   int   errors = 0;
   int   checks = 0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (cyc < HIST) hist[cyc] <= tx;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d, output int n);
      @(negedge clk);
      data_addr  = a;
      write_data = d;
      mem_write  = 1'b1;
      @(posedge clk);
      #1;
      n          = cyc;
      mem_write  = 1'b0;
      data_addr  = 32'h0;
      write_data = 32'h0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] v);
      data_addr = a;
      #1;
      v = rd_data;
      data_addr = 32'h0;
   endtask

   // Returns on the falling edge after hist[target] has been written
   task automatic wait_cyc(input int target);
      while (cyc <= target) @(negedge clk);
   endtask

   function automatic logic [63:0] frame_got(input int s);
      logic [63:0] v = '0;
      for (int k = 0; k < 10 * CLK_DIV; k++) v[k] = hist[s + k];
      return v;
   endfunction

   function automatic logic [63:0] frame_exp(input logic [7:0] b);
      logic [63:0] v = '0;
      for (int k = 0; k < 10 * CLK_DIV; k++) begin
         int idx = k / CLK_DIV;
         if (idx == 0)      v[k] = 1'b0;
         else if (idx == 9) v[k] = 1'b1;
         else               v[k] = b[idx - 1];
      end
      return v;
   endfunction

   function automatic int zeros_in(input int s, input int len);
      int z = 0;
      for (int k = 0; k < len; k++) if (hist[s + k] !== 1'b1) z++;
      return z;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          n;
      int          n0;
      int          r;
      logic [31:0] v;
      logic [7:0]  three [3];

      three[0] = 8'h3C;
      three[1] = 8'hC3;
      three[2] = 8'h81;

      // Reset state and address decode
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_tx", 64'(tx), 64'd1);
      rd(32'h0000_1004, v);
      chk("rst_status", 64'(v), 64'h2);
      data_addr = 32'h0000_2000;
      #1;
      chk("sel_outside", 64'(sel), 64'd0);
      chk("rd_outside", 64'(rd_data), 64'd0);
      data_addr = 32'h0000_1004;
      #1;
      chk("sel_inside", 64'(sel), 64'd1);
      rd(32'h0000_1000, v);
      chk("txdata_reads0", 64'(v), 64'd0);
      rd(32'h0000_1008, v);
      chk("rd_next_window", 64'(v), 64'd0);

      // Store outside the window must not start a frame
      store(32'h0000_2000, 32'h55, n);
      wait_cyc(n + 12);
      chk("outside_no_frame", 64'(zeros_in(n, 12)), 64'd0);

      // Single byte A5: tx falls one edge after the store, 40-cycle frame
      store(32'h0000_1000, 32'hFFFF_FFA5, n);
      chk("a5_pre", 64'(tx), 64'd1);
      wait_cyc(n + 42);
      chk("a5_frame", frame_got(n + 1), frame_exp(8'hA5));
      chk("a5_after", 64'(hist[n + 41]), 64'd1);

      // STATUS bit4 write: R/W enable with the irq option, ignored otherwise
      store(32'h0000_1004, 32'h10, n);
      rd(32'h0000_1004, v);
`ifdef MMIO_UART_IRQ_EN
      chk("status_bit4", 64'(v), 64'h12);
`else
      chk("status_bit4", 64'(v), 64'h02);
`endif

      // Three back-to-back stores: contiguous frames
      store(32'h0000_1000, 32'(three[0]), n0);
      store(32'h0000_1000, 32'(three[1]), n);
      store(32'h0000_1000, 32'(three[2]), n);
      wait_cyc(n0 + 1 + 120 + 2);
      for (int i = 0; i < 3; i++)
         chk($sformatf("b2b_frame%0d", i), frame_got(n0 + 1 + 40 * i), frame_exp(three[i]));
      chk("b2b_after", 64'(hist[n0 + 121]), 64'd1);
      rd(32'h0000_1004, v);
      chk("b2b_status", 64'(v & 32'hFFFF_FFEF), 64'h2);

      // 18 stores during the first frame: 16 buffered, 1 dropped
      for (int i = 0; i < 18; i++) begin
         store(32'h0000_1000, 32'(8'h40 + i), n);
         if (i == 0) n0 = n;
      end
      rd(32'h0000_1004, v);
      chk("ovf_status", 64'(v & 32'hFFFF_FFEF), 64'h100D);
      store(32'h0000_1004, 32'h8, n);
      rd(32'h0000_1004, v);
      chk("ovf_w1c", 64'(v & 32'hFFFF_FFEF), 64'h1005);
      wait_cyc(n0 + 1 + 17 * 40 + 60);
      for (int i = 0; i < 17; i++)
         chk($sformatf("ovf_frame%0d", i), frame_got(n0 + 1 + 40 * i), frame_exp(8'(8'h40 + i)));
      chk("ovf_no_18th", 64'(zeros_in(n0 + 1 + 17 * 40, 60)), 64'd0);

      // Reset in the middle of a frame with more bytes queued
      store(32'h0000_1000, 32'h00, n);
      store(32'h0000_1000, 32'h11, r);
      store(32'h0000_1000, 32'h22, r);
      wait_cyc(n + 1 + 17);
      chk("mid_frame_low", 64'(tx), 64'd0);
      #1;
      reset = 1'b1;
      #1;
      chk("rst_async_tx", 64'(tx), 64'd1);
      rd(32'h0000_1004, v);
      chk("rst_mid_status", 64'(v), 64'h2);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      r = cyc;
      wait_cyc(r + 100);
      chk("rst_no_frames", 64'(zeros_in(r, 100)), 64'd0);
      rd(32'h0000_1004, v);
      chk("rst_after_status", 64'(v), 64'h2);

`ifdef MMIO_UART_IRQ_EN
      // Interrupt: low during the frame, high one cycle after reaching IDLE
      store(32'h0000_1004, 32'h10, n);
      store(32'h0000_1000, 32'h5A, n);
      wait_cyc(n + 1 + 20);
      chk("irq_mid_frame", 64'(irq), 64'd0);
      wait_cyc(n + 1 + 39);
      chk("irq_at_idle_entry", 64'(irq), 64'd0);
      @(negedge clk);
      chk("irq_after_idle", 64'(irq), 64'd1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
